// File: rtl/multicycle_ctrl_v2.sv
// Multicycle MIPS control FSM: decodes op/funct and sequences PC, IR, ALU-mux, regfile and memory controls.
// Latency: LW 5, SW 4, R/I 4, branch/jump/JR/JAL/trap 3 cycles; every memory wait cycle adds one.
// Backpressure: FETCH, LWRD and SWWR hold with their strobes asserted until mem_ready (when MEM_WAIT_EN=1).
module multicycle_ctrl_v2 #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter bit BR_EXT      = 1'b1,
    parameter int ALUOP_W     = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         i_op,
    input  logic [5:0]         i_funct,
    input  logic               i_zero,
    input  logic               i_sign,
    input  logic               i_mem_ready,
    output logic               o_memread,
    output logic               o_memwrite,
    output logic               o_iord,
    output logic               o_irwrite,
    output logic               o_pcen,
    output logic [1:0]         o_pcsource,
    output logic [1:0]         o_alusrca,
    output logic [1:0]         o_alusrcb,
    output logic [ALUOP_W-1:0] o_aluop,
    output logic               o_sori,
    output logic               o_regwrite,
    output logic [1:0]         o_regdst,
    output logic               o_memtoreg,
    output logic               o_link,
    output logic               o_illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] F_JR     = 6'b001000;

    // 5-bit encoding leaves unused codes; those fall into the recovery arm below.
    typedef enum logic [4:0] {
        S_FETCH  = 5'd0,  S_DECODE = 5'd1,  S_MEMADR = 5'd2,  S_LWRD  = 5'd3,
        S_LWWR   = 5'd4,  S_SWWR   = 5'd5,  S_REX    = 5'd6,  S_RSHIFT = 5'd7,
        S_RWR    = 5'd8,  S_BREX   = 5'd9,  S_JEX    = 5'd10, S_JR    = 5'd11,
        S_JALEX  = 5'd12, S_IEX    = 5'd13, S_IWR    = 5'd14, S_TRAP  = 5'd15
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_ready;
    logic   w_funct_ok;
    logic   w_taken;

    // Single-cycle memory mode treats every access as complete.
    assign w_ready    = i_mem_ready || !MEM_WAIT_EN;
    // Non-shift, non-JR R-type functions the datapath implements.
    assign w_funct_ok = i_funct inside {6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                        6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};

    // Branch condition from the ALU compare flags, selected by opcode.
    always_comb begin
        w_taken = 1'b0;
        case (i_op)
            OP_BEQ:  w_taken = i_zero;
            OP_BNE:  w_taken = !i_zero;
            OP_BLEZ: w_taken = i_sign || i_zero;
            OP_BGTZ: w_taken = !i_sign && !i_zero;
            default: w_taken = 1'b0;
        endcase
    end

    // State register; a synchronous reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Next state and Moore/Mealy outputs; everything stays 0 while reset is high.
    always_comb begin
        w_next     = r_state;
        o_memread  = 1'b0;
        o_memwrite = 1'b0;
        o_iord     = 1'b0;
        o_irwrite  = 1'b0;
        o_pcen     = 1'b0;
        o_pcsource = 2'b00;
        o_alusrca  = 2'b00;
        o_alusrcb  = 2'b00;
        o_aluop    = '0;
        o_sori     = 1'b0;
        o_regwrite = 1'b0;
        o_regdst   = 2'b00;
        o_memtoreg = 1'b0;
        o_link     = 1'b0;
        o_illegal  = 1'b0;
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    o_memread = 1'b1;
                    o_alusrcb = 2'b01;
                    o_irwrite = w_ready;
                    o_pcen    = w_ready;
                    if (w_ready) w_next = S_DECODE;
                end
                S_DECODE: begin
                    o_alusrcb = 2'b11;
                    case (i_op)
                        OP_RTYPE: begin
                            if (i_funct[5:2] == 4'b0000) w_next = S_RSHIFT;
                            else if (i_funct == F_JR)    w_next = S_JR;
                            else if (w_funct_ok)         w_next = S_REX;
                            else                         w_next = S_TRAP;
                        end
                        OP_LW, OP_SW:              w_next = S_MEMADR;
                        OP_BEQ:                    w_next = S_BREX;
                        OP_BNE, OP_BLEZ, OP_BGTZ:  w_next = BR_EXT ? S_BREX : S_TRAP;
                        OP_J:                      w_next = S_JEX;
                        OP_JAL:                    w_next = S_JALEX;
                        OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
                        OP_ORI, OP_XORI, OP_LUI:   w_next = S_IEX;
                        default:                   w_next = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    o_alusrca = 2'b01;
                    o_alusrcb = 2'b10;
                    w_next    = (i_op == OP_SW) ? S_SWWR : S_LWRD;
                end
                S_LWRD: begin
                    o_memread = 1'b1;
                    o_iord    = 1'b1;
                    if (w_ready) w_next = S_LWWR;
                end
                S_LWWR: begin
                    o_regwrite = 1'b1;
                    o_memtoreg = 1'b1;
                    w_next     = S_FETCH;
                end
                S_SWWR: begin
                    o_memwrite = 1'b1;
                    o_iord     = 1'b1;
                    if (w_ready) w_next = S_FETCH;
                end
                S_REX: begin
                    o_alusrca = 2'b01;
                    o_aluop   = ALUOP_W'(2);
                    w_next    = S_RWR;
                end
                S_RSHIFT: begin
                    o_alusrca = 2'b10;
                    o_aluop   = ALUOP_W'(2);
                    o_sori    = 1'b1;
                    w_next    = S_RWR;
                end
                S_RWR: begin
                    o_regwrite = 1'b1;
                    o_regdst   = 2'b01;
                    w_next     = S_FETCH;
                end
                S_BREX: begin
                    o_alusrca  = 2'b01;
                    o_aluop    = ALUOP_W'(1);
                    o_pcsource = 2'b01;
                    o_pcen     = w_taken;
                    w_next     = S_FETCH;
                end
                S_JEX: begin
                    o_pcen     = 1'b1;
                    o_pcsource = 2'b10;
                    w_next     = S_FETCH;
                end
                S_JR: begin
                    o_pcen     = 1'b1;
                    o_pcsource = 2'b11;
                    w_next     = S_FETCH;
                end
                S_JALEX: begin
                    // PC was already advanced by 4 in FETCH, so it is the link value.
                    o_pcen     = 1'b1;
                    o_pcsource = 2'b10;
                    o_regwrite = 1'b1;
                    o_regdst   = 2'b10;
                    o_link     = 1'b1;
                    w_next     = S_FETCH;
                end
                S_IEX: begin
                    o_alusrca = 2'b01;
                    o_alusrcb = 2'b10;
                    o_aluop   = ALUOP_W'(i_op);
                    w_next    = S_IWR;
                end
                S_IWR: begin
                    o_regwrite = 1'b1;
                    w_next     = S_FETCH;
                end
                S_TRAP: begin
                    o_illegal = 1'b1;
                    w_next    = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: instruction-level reference model checked every cycle.
// Latency: inputs driven on the falling edge, outputs compared 1 time unit later.
// Backpressure: mem_ready is randomised/scripted per wait step of each instruction.
module tb_multicycle_ctrl_v2;

    typedef struct packed {
        logic       memread, memwrite, iord, irwrite, pcen;
        logic [1:0] pcsource, alusrca, alusrcb;
        logic [5:0] aluop;
        logic       sori, regwrite;
        logic [1:0] regdst;
        logic       memtoreg, link, illegal;
    } ctl_t;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_SH = 3, C_JR = 4, C_BR = 5,
                   C_J = 6, C_JAL = 7, C_I = 8, C_TRAP = 9;

    logic       clk, reset;
    logic [5:0] i_op, i_funct;
    logic       i_zero, i_sign, i_mem_ready;

    logic o_memread, o_memwrite, o_iord, o_irwrite, o_pcen, o_sori, o_regwrite, o_memtoreg, o_link, o_illegal;
    logic [1:0] o_pcsource, o_alusrca, o_alusrcb, o_regdst;
    logic [5:0] o_aluop;
    logic n_memread, n_memwrite, n_iord, n_irwrite, n_pcen, n_sori, n_regwrite, n_memtoreg, n_link, n_illegal;
    logic [1:0] n_pcsource, n_alusrca, n_alusrcb, n_regdst;
    logic [5:0] n_aluop;

    multicycle_ctrl_v2 u_dut (
        .clk(clk), .reset(reset), .i_op(i_op), .i_funct(i_funct), .i_zero(i_zero), .i_sign(i_sign),
        .i_mem_ready(i_mem_ready), .o_memread(o_memread), .o_memwrite(o_memwrite), .o_iord(o_iord),
        .o_irwrite(o_irwrite), .o_pcen(o_pcen), .o_pcsource(o_pcsource), .o_alusrca(o_alusrca),
        .o_alusrcb(o_alusrcb), .o_aluop(o_aluop), .o_sori(o_sori), .o_regwrite(o_regwrite),
        .o_regdst(o_regdst), .o_memtoreg(o_memtoreg), .o_link(o_link), .o_illegal(o_illegal)
    );

    // Variant without memory waits and without extended branches, driven by the same inputs.
    multicycle_ctrl_v2 #(.MEM_WAIT_EN(1'b0), .BR_EXT(1'b0)) u_nb (
        .clk(clk), .reset(reset), .i_op(i_op), .i_funct(i_funct), .i_zero(i_zero), .i_sign(i_sign),
        .i_mem_ready(i_mem_ready), .o_memread(n_memread), .o_memwrite(n_memwrite), .o_iord(n_iord),
        .o_irwrite(n_irwrite), .o_pcen(n_pcen), .o_pcsource(n_pcsource), .o_alusrca(n_alusrca),
        .o_alusrcb(n_alusrcb), .o_aluop(n_aluop), .o_sori(n_sori), .o_regwrite(n_regwrite),
        .o_regdst(n_regdst), .o_memtoreg(n_memtoreg), .o_link(n_link), .o_illegal(n_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_chk = 0, n_fail = 0;
    int   m_k = 0;                 // cycle-step index within the current instruction
    int   cnt_irw, cnt_ill, cnt_ill_nb;
    ctl_t log_main [0:7];
    ctl_t log_nb   [0:7];
    logic [5:0] op_pool [0:18];
    logic [5:0] fn_pool [0:15];

    // Instruction class from the opcode table.
    function automatic int classify(input logic [5:0] op, input logic [5:0] fn, input bit br_ext);
        int o, f;
        o = int'(op);
        f = int'(fn);
        if (o == 0) begin
            if (f < 4) return C_SH;
            if (f == 8) return C_JR;
            if ((f >= 32 && f <= 39) || f == 42 || f == 43) return C_R;
            return C_TRAP;
        end
        if (o == 2) return C_J;
        if (o == 3) return C_JAL;
        if (o == 4) return C_BR;
        if (o >= 5 && o <= 7) return br_ext ? C_BR : C_TRAP;
        if (o >= 8 && o <= 15 && o != 11) return C_I;
        if (o == 35) return C_LW;
        if (o == 43) return C_SW;
        return C_TRAP;
    endfunction

    function automatic int instr_len(input int cls);
        if (cls == C_LW) return 5;
        if (cls == C_SW || cls == C_R || cls == C_SH || cls == C_I) return 4;
        return 3;
    endfunction

    function automatic bit is_wait(input int cls, input int k);
        return (k == 0) || (k == 3 && (cls == C_LW || cls == C_SW));
    endfunction

    // Expected control word for step k of an instruction of class cls.
    function automatic ctl_t model_out(input int cls, input int k, input logic rdy, input logic z,
                                       input logic s, input logic [5:0] op);
        ctl_t e;
        e = '0;
        if (k == 0) begin
            e.memread = 1'b1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcen = rdy;
        end else if (k == 1) begin
            e.alusrcb = 2'b11;
        end else begin
            case (cls)
                C_LW, C_SW: begin
                    if (k == 2) begin e.alusrca = 2'b01; e.alusrcb = 2'b10; end
                    else if (k == 3 && cls == C_LW) begin e.memread = 1'b1; e.iord = 1'b1; end
                    else if (k == 3) begin e.memwrite = 1'b1; e.iord = 1'b1; end
                    else begin e.regwrite = 1'b1; e.memtoreg = 1'b1; end
                end
                C_R, C_SH: begin
                    if (k == 2) begin
                        e.alusrca = (cls == C_SH) ? 2'b10 : 2'b01;
                        e.aluop = 6'd2;
                        e.sori = (cls == C_SH);
                    end else begin e.regwrite = 1'b1; e.regdst = 2'b01; end
                end
                C_I: begin
                    if (k == 2) begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.aluop = op; end
                    else e.regwrite = 1'b1;
                end
                C_BR: begin
                    e.alusrca = 2'b01; e.aluop = 6'd1; e.pcsource = 2'b01;
                    case (int'(op))
                        4: e.pcen = z;
                        5: e.pcen = !z;
                        6: e.pcen = s | z;
                        default: e.pcen = !s & !z;
                    endcase
                end
                C_J:   begin e.pcen = 1'b1; e.pcsource = 2'b10; end
                C_JR:  begin e.pcen = 1'b1; e.pcsource = 2'b11; end
                C_JAL: begin e.pcen = 1'b1; e.pcsource = 2'b10; e.regwrite = 1'b1; e.regdst = 2'b10; e.link = 1'b1; end
                default: e.illegal = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic check(input string name, input int got, input int req);
        n_chk++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // One clock: drive, compare the main DUT against the model, then advance the model.
    task automatic cycle(input logic rst, input logic rdy, input logic z, input logic s);
        ctl_t got, gnb, exp;
        int   cls;
        @(negedge clk);
        reset = rst; i_mem_ready = rdy; i_zero = z; i_sign = s;
        #1;
        cls = classify(i_op, i_funct, 1'b1);
        exp = rst ? ctl_t'('0) : model_out(cls, m_k, rdy, z, s, i_op);
        got = {o_memread, o_memwrite, o_iord, o_irwrite, o_pcen, o_pcsource, o_alusrca, o_alusrcb,
               o_aluop, o_sori, o_regwrite, o_regdst, o_memtoreg, o_link, o_illegal};
        gnb = {n_memread, n_memwrite, n_iord, n_irwrite, n_pcen, n_pcsource, n_alusrca, n_alusrcb,
               n_aluop, n_sori, n_regwrite, n_regdst, n_memtoreg, n_link, n_illegal};
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ctl op=%b fn=%b step=%0d rst=%b rdy=%b: got %h, required %h",
                     i_op, i_funct, m_k, rst, rdy, got, exp);
        end
        if (m_k < 8) begin log_main[m_k] = got; log_nb[m_k] = gnb; end
        cnt_irw    += int'(got.irwrite);
        cnt_ill    += int'(got.illegal);
        cnt_ill_nb += int'(gnb.illegal);
        if (rst) m_k = 0;
        else if (!(is_wait(cls, m_k) && !rdy)) m_k = (m_k + 1 == instr_len(cls)) ? 0 : m_k + 1;
    endtask

    // Run one whole instruction; wait steps see 'waits' not-ready cycles before ready.
    task automatic run_instr(input logic [5:0] op_v, input logic [5:0] fn_v, input int waits,
                             input bit rnd, input logic z, input logic s, output int ncyc);
        int   w;
        bit   left, wb;
        logic rdy, zz, ss;
        w = 0; left = 0; ncyc = 0; cnt_irw = 0; cnt_ill = 0; cnt_ill_nb = 0;
        for (int j = 0; j < 8; j++) begin log_main[j] = '0; log_nb[j] = '0; end
        i_op = op_v; i_funct = fn_v;
        while (!(left && m_k == 0)) begin
            if (ncyc >= 60) begin
                n_chk++; n_fail++;
                $display("FAIL timeout op=%b: busy after %0d cycles, required completion", op_v, ncyc);
                return;
            end
            wb  = is_wait(classify(op_v, fn_v, 1'b1), m_k);
            rdy = wb ? (w >= waits) : 1'($urandom_range(0, 1));
            zz  = rnd ? 1'($urandom_range(0, 1)) : z;
            ss  = rnd ? 1'($urandom_range(0, 1)) : s;
            cycle(1'b0, rdy, zz, ss);
            w = (wb && !rdy) ? w + 1 : 0;
            if (m_k != 0) left = 1;
            ncyc++;
        end
    endtask

    int        nc;
    logic [5:0] rop, rfn;
    int        blez_exp [0:2];
    int        bgtz_exp [0:2];
    logic [1:0] sz_tab  [0:2];

    initial begin
        op_pool  = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10,
                     6'd12, 6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd63, 6'd11, 6'd32};
        fn_pool  = '{6'd0, 6'd2, 6'd3, 6'd8, 6'd32, 6'd33, 6'd34, 6'd35,
                     6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43, 6'd9, 6'd63};
        sz_tab   = '{2'b00, 2'b01, 2'b10};   // {sign, zero}
        blez_exp = '{0, 1, 1};
        bgtz_exp = '{1, 0, 0};
        reset = 1'b1; i_op = '0; i_funct = '0; i_zero = 1'b0; i_sign = 1'b0; i_mem_ready = 1'b0;

        // Reset: all outputs low.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_memread", int'(o_memread), 0);
        check("reset_pcen", int'(o_pcen), 0);

        // FETCH stalled: main DUT holds, no-wait variant loads IR anyway.
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("fetch_stall_memread", int'(o_memread), 1);
        check("fetch_stall_irwrite", int'(o_irwrite), 0);
        check("nowait_fetch_irwrite", int'(n_irwrite), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // LW with two wait cycles in FETCH and LWRD.
        run_instr(6'b100011, 6'd0, 2, 1'b0, 1'b0, 1'b0, nc);
        check("lw_wait_cycles", nc, 9);
        check("lw_irwrite_count", cnt_irw, 1);
        check("lw_wb_memtoreg", int'(log_main[4].memtoreg), 1);

        // BNE taken/not taken; BR_EXT=0 variant traps on the same instruction.
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        run_instr(6'b000101, 6'd0, 0, 1'b0, 1'b0, 1'b0, nc);
        check("bne_taken_pcen", int'(log_main[2].pcen), 1);
        check("bne_pcsource", int'(log_main[2].pcsource), 1);
        check("bne_noext_illegal", int'(log_nb[2].illegal), 1);
        check("bne_noext_illegal_cnt", cnt_ill_nb, 1);
        run_instr(6'b000101, 6'd0, 0, 1'b0, 1'b1, 1'b0, nc);
        check("bne_not_taken_pcen", int'(log_main[2].pcen), 0);

        // BLEZ / BGTZ against {sign,zero} = 00, 01, 10.
        for (int i = 0; i < 3; i++) begin
            run_instr(6'b000110, 6'd0, 0, 1'b0, sz_tab[i][0], sz_tab[i][1], nc);
            check($sformatf("blez_taken_%0d", i), int'(log_main[2].pcen), blez_exp[i]);
            run_instr(6'b000111, 6'd0, 0, 1'b0, sz_tab[i][0], sz_tab[i][1], nc);
            check($sformatf("bgtz_taken_%0d", i), int'(log_main[2].pcen), bgtz_exp[i]);
        end

        // JAL.
        run_instr(6'b000011, 6'd0, 0, 1'b0, 1'b0, 1'b0, nc);
        check("jal_cycles", nc, 3);
        check("jal_regdst", int'(log_main[2].regdst), 2);
        check("jal_link", int'(log_main[2].link), 1);
        check("jal_pcsource", int'(log_main[2].pcsource), 2);

        // Undefined opcode traps.
        run_instr(6'b111111, 6'd0, 0, 1'b0, 1'b0, 1'b0, nc);
        check("trap_cycles", nc, 3);
        check("trap_illegal_cnt", cnt_ill, 1);
        check("trap_regwrite", int'(log_main[2].regwrite), 0);

        // Reset during a stalled store.
        i_op = 6'b101011; i_funct = '0;
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("swwr_memwrite", int'(o_memwrite), 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("sw_reset_memwrite", int'(o_memwrite), 0);
        check("sw_reset_pcen", int'(o_pcen), 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        check("sw_reset_fetch_memread", int'(o_memread), 1);
        check("sw_reset_fetch_iord", int'(o_iord), 0);

        // Randomised instruction stream.
        for (int n = 0; n < 400; n++) begin
            rop = ($urandom_range(0, 9) < 8) ? op_pool[$urandom_range(0, 18)] : 6'($urandom);
            rfn = ($urandom_range(0, 9) < 8) ? fn_pool[$urandom_range(0, 15)] : 6'($urandom);
            run_instr(rop, rfn, $urandom_range(0, 2), 1'b1, 1'b0, 1'b0, nc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
